// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide sequencer.
//   - OP_*   : decoded mul/div opcode from the control unit (6/7 are illegal)
//   - SEL_*  : HI/LO write-data source select codes
//   - state_e: sequencer FSM states
//   - wb_sel : maps a captured MULT/MULTU/DIV/DIVU op to its HI/LO source
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [2:0] SEL_DIVU  = 3'd0;
    localparam logic [2:0] SEL_DIV   = 3'd1;
    localparam logic [2:0] SEL_MULTU = 3'd2;
    localparam logic [2:0] SEL_RS    = 3'd3;
    localparam logic [2:0] SEL_MULT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_WB       = 2'd3
    } state_e;

    function automatic logic [2:0] wb_sel(input logic [2:0] op);
        case (op)
            OP_MULT:  wb_sel = SEL_MULT;
            OP_MULTU: wb_sel = SEL_MULTU;
            OP_DIV:   wb_sel = SEL_DIV;
            default:  wb_sel = SEL_DIVU;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// muldiv_cnt: loadable down-counter with zero flag, times the multiplier latency.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; holds at zero
//   zero_o      : count is zero
module muldiv_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencer for the shared HI/LO multiply/divide resources.
// Issues MULT/MULTU/DIV/DIVU/MTHI/MTLO, pulses the divider starts, waits out
// the multiplier latency or the divider busy handshake, then writes HI/LO.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   op_valid, op           : decoded request (sampled in IDLE only)
//   divisor_zero           : Rt==0 at issue
//   div_busy, divu_busy    : divider busy flags (observed in DIV_WAIT only)
//   div_start, divu_start  : one-cycle divider start pulses (IDLE decode)
//   hi_ena, lo_ena, hilo_sel : HI/LO write enables and source select
//   stall                  : hold PC while an op is in flight
//   done                   : one-cycle pulse in the write-back cycle
// Optional build macro MULDIV_DIV0_EXC_EN adds div0_exc, pulsed in the WB
// cycle of a divide by zero.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [2:0] op,
    input  logic       divisor_zero,
    input  logic       div_busy,
    input  logic       divu_busy,
    output logic       div_start,
    output logic       divu_start,
    output logic       hi_ena,
    output logic       lo_ena,
    output logic [2:0] hilo_sel,
    output logic       stall,
    output logic       done
`ifdef MULDIV_DIV0_EXC_EN
    ,
    output logic       div0_exc
`endif
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       nowrite_q, nowrite_d;
    logic       seen_busy_q, seen_busy_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       sel_busy;
    logic       exc;

    // Only the divider that was started is watched.
    assign sel_busy = (op_q == OP_DIVU) ? divu_busy : div_busy;

    muldiv_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (MUL_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            nowrite_q   <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            nowrite_q   <= nowrite_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        nowrite_d   = nowrite_q;
        seen_busy_d = seen_busy_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            op_d      = op;
                            nowrite_d = 1'b0;
                            cnt_load  = 1'b1;
                            state_d   = ST_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d = op;
                            if (divisor_zero) begin
                                nowrite_d = 1'b1;
                                state_d   = ST_WB;
                            end else begin
                                nowrite_d   = 1'b0;
                                seen_busy_d = 1'b0;
                                state_d     = ST_DIV_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_zero) state_d = ST_WB;
                else          cnt_dec = 1'b1;
            end
            ST_DIV_WAIT: begin
                // Wait for a busy rise then its fall, so a divider that is
                // slow to raise busy is not mistaken for one already done.
                if (sel_busy) seen_busy_d = 1'b1;
                if (seen_busy_q && !sel_busy) state_d = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs forced low while reset is held, including IDLE decode.
    always_comb begin
        div_start  = 1'b0;
        divu_start = 1'b0;
        hi_ena     = 1'b0;
        lo_ena     = 1'b0;
        hilo_sel   = SEL_DIVU;
        stall      = 1'b0;
        done       = 1'b0;
        exc        = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MTHI: begin
                                hi_ena   = 1'b1;
                                hilo_sel = SEL_RS;
                            end
                            OP_MTLO: begin
                                lo_ena   = 1'b1;
                                hilo_sel = SEL_RS;
                            end
                            OP_MULT, OP_MULTU: stall = 1'b1;
                            OP_DIV: begin
                                stall     = 1'b1;
                                div_start = !divisor_zero;
                            end
                            OP_DIVU: begin
                                stall      = 1'b1;
                                divu_start = !divisor_zero;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL_WAIT, ST_DIV_WAIT: stall = 1'b1;
                ST_WB: begin
                    done     = 1'b1;
                    hilo_sel = wb_sel(op_q);
                    hi_ena   = !nowrite_q;
                    lo_ena   = !nowrite_q;
                    exc      = nowrite_q;
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIV0_EXC_EN
    assign div0_exc = exc;
`else
    logic unused_exc;
    assign unused_exc = exc;
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched (MUL_LAT=3): table of zero-latency IDLE requests,
// followed by hand-written multi-cycle sequences.
module tb_muldiv_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic [2:0] op;
    logic       divisor_zero;
    logic       div_busy;
    logic       divu_busy;
    logic       div_start;
    logic       divu_start;
    logic       hi_ena;
    logic       lo_ena;
    logic [2:0] hilo_sel;
    logic       stall;
    logic       done;
`ifdef MULDIV_DIV0_EXC_EN
    logic       div0_exc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sched #(.MUL_LAT(3), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .divisor_zero (divisor_zero),
        .div_busy     (div_busy),
        .divu_busy    (divu_busy),
        .div_start    (div_start),
        .divu_start   (divu_start),
        .hi_ena       (hi_ena),
        .lo_ena       (lo_ena),
        .hilo_sel     (hilo_sel),
        .stall        (stall),
        .done         (done)
`ifdef MULDIV_DIV0_EXC_EN
        ,
        .div0_exc     (div0_exc)
`endif
    );

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic       hi;
        logic       lo;
        logic [2:0] sel;
        logic       stall;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string name, input logic [2:0] sel, input logic wr);
        chk({name, "_done"},  done,     1'b1);
        chk({name, "_stall"}, stall,    1'b0);
        chk({name, "_hi"},    hi_ena,   wr);
        chk({name, "_lo"},    lo_ena,   wr);
        chk({name, "_sel"},   hilo_sel, sel);
    endtask

    int starts;
    int bad;

    initial begin
        tbl[0] = '{v:1'b0, op:3'd0, hi:1'b0, lo:1'b0, sel:3'd0, stall:1'b0};
        tbl[1] = '{v:1'b1, op:3'd4, hi:1'b1, lo:1'b0, sel:3'd3, stall:1'b0};
        tbl[2] = '{v:1'b1, op:3'd5, hi:1'b0, lo:1'b1, sel:3'd3, stall:1'b0};
        tbl[3] = '{v:1'b1, op:3'd6, hi:1'b0, lo:1'b0, sel:3'd0, stall:1'b0};
        tbl[4] = '{v:1'b1, op:3'd7, hi:1'b0, lo:1'b0, sel:3'd0, stall:1'b0};
        tbl[5] = '{v:1'b0, op:3'd4, hi:1'b0, lo:1'b0, sel:3'd0, stall:1'b0};

        // Reset with an MTLO request present: everything must stay low.
        reset = 1'b1; op_valid = 1'b1; op = 3'd5;
        divisor_zero = 1'b0; div_busy = 1'b0; divu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_lo",    lo_ena,   1'b0);
        chk("rst_hi",    hi_ena,   1'b0);
        chk("rst_stall", stall,    1'b0);
        chk("rst_done",  done,     1'b0);
        chk("rst_sel",   hilo_sel, 3'd0);
        #1 reset = 1'b0; op_valid = 1'b0;

        // Zero-latency IDLE requests; each stays in IDLE.
        for (int i = 0; i < 6; i++) begin
            cyc();
            op_valid = tbl[i].v; op = tbl[i].op;
            #1;
            chk($sformatf("tbl%0d_hi", i),    hi_ena,   tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i),    lo_ena,   tbl[i].lo);
            chk($sformatf("tbl%0d_sel", i),   hilo_sel, tbl[i].sel);
            chk($sformatf("tbl%0d_stall", i), stall,    tbl[i].stall);
            chk($sformatf("tbl%0d_misc", i),  {done, div_start, divu_start}, 3'b000);
        end
        cyc();
        op_valid = 1'b0;
        #1 chk("idle_after_tbl", {stall, done}, 2'b00);

        // MULT, MUL_LAT=3; op_valid held through WB, op=6 on return to IDLE.
        cyc();
        op_valid = 1'b1; op = 3'd0;
        #1;
        chk("mult_issue_stall", stall, 1'b1);
        chk("mult_issue_wr", {hi_ena, lo_ena, done}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk($sformatf("mult_wait%0d", i), {stall, done}, 2'b10);
        end
        cyc();
        op = 3'd6;
        #1 chk_wb("mult_wb", 3'd4, 1'b1);
        cyc();
        #1;
        chk("illegal_idle", {stall, hi_ena, lo_ena, done}, 4'b0000);
        cyc();
        #1 chk("no_reissue", {stall, done, div_start, divu_start}, 4'b0000);
        op_valid = 1'b0;

        // DIVU with 33-cycle busy.
        cyc();
        op_valid = 1'b1; op = 3'd3; divisor_zero = 1'b0;
        #1;
        chk("divu_issue_start", {divu_start, div_start}, 2'b10);
        chk("divu_issue_stall", stall, 1'b1);
        cyc();
        op_valid = 1'b0; divu_busy = 1'b1;
        starts = 0; bad = 0;
        for (int i = 0; i < 33; i++) begin
            #1;
            if (divu_start || div_start) starts++;
            if (!stall || done) bad++;
            cyc();
        end
        divu_busy = 1'b0;
        #1 chk("divu_fall_stall", {stall, done}, 2'b10);
        chk("divu_no_repulse", starts, 0);
        chk("divu_wait_stall", bad, 0);
        cyc();
        #1 chk_wb("divu_wb", 3'd0, 1'b1);

        // DIV by zero.
        cyc();
        op_valid = 1'b1; op = 3'd2; divisor_zero = 1'b1;
        #1;
        chk("div0_no_start", {div_start, divu_start}, 2'b00);
        chk("div0_stall", stall, 1'b1);
        cyc();
        op_valid = 1'b0; divisor_zero = 1'b0;
        #1 chk_wb("div0_wb", 3'd1, 1'b0);
`ifdef MULDIV_DIV0_EXC_EN
        chk("div0_exc", div0_exc, 1'b1);
`endif
        cyc();
        #1 chk("div0_after", {done, stall}, 2'b00);
`ifdef MULDIV_DIV0_EXC_EN
        chk("div0_exc_after", div0_exc, 1'b0);
`endif

        // Reset five cycles into DIV_WAIT.
        cyc();
        op_valid = 1'b1; op = 3'd2;
        #1 chk("div_issue_start", {div_start, divu_start}, 2'b10);
        cyc();
        op_valid = 1'b0; div_busy = 1'b1;
        repeat (4) cyc();
        #1 chk("div_wait5_stall", stall, 1'b1);
        op_valid = 1'b1; op = 3'd4;
        #1 reset = 1'b1;
        #1 chk("midrst_outs", {stall, hi_ena, lo_ena, done, hilo_sel}, 7'd0);
        cyc();
        #1 chk("midrst_held", {stall, hi_ena}, 2'b00);
        reset = 1'b0; div_busy = 1'b0;
        #1 chk("post_rst_idle_mthi", {hi_ena, stall}, 2'b10);
        cyc();
        op_valid = 1'b1; op = 3'd1;
        #1 chk("multu_issue_stall", stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            op_valid = 1'b0;
            #1 chk($sformatf("multu_wait%0d", i), {stall, done}, 2'b10);
        end
        cyc();
        #1 chk_wb("multu_wb", 3'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
